uart_rx_ctrl_param: RTL and testbench

Parametrised UART receive controller: samples the serial line in a single clock domain, recovers and deserialises frames of DATA_WIDTH bits with optional even/odd parity and one or two stop bits, and reports data plus per-frame error flags. It is the next-generation UART_RX core. It merges sequencing, edge/bit counting, majority-vote sampling and deserialisation into one block, and sits between the RX_IN line synchroniser and the receive FIFO/register-file path.

---
 rtl/uart_rx_ctrl_param_if.sv | 36 +++
 rtl/uart_rx_ctrl_param.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_rx_ctrl_param.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ctrl_param_if.sv
// ----------------------------------------------------------------------------
// uart_rx_ctrl_param_if
//   Bundles the serial line, per-frame configuration and receive results of
//   uart_rx_ctrl_param.
//   master : line/config driver (synchroniser side), observes results
//   slave  : the receive controller
//   RX_IN, Prescale, Par_En, Par_Typ, Stp_2          master -> slave
//   P_DATA, Data_Valid, Par_Err, Stp_Err, Brk_Det,
//   Busy                                             slave  -> master
// ----------------------------------------------------------------------------
interface uart_rx_ctrl_param_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 6
);
  logic                  RX_IN;
  logic [PRESCALE_W-1:0] Prescale;
  logic                  Par_En;
  logic                  Par_Typ;
  logic                  Stp_2;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  Par_Err;
  logic                  Stp_Err;
  logic                  Brk_Det;
  logic                  Busy;

  modport master (
    output RX_IN, Prescale, Par_En, Par_Typ, Stp_2,
    input  P_DATA, Data_Valid, Par_Err, Stp_Err, Brk_Det, Busy
  );

  modport slave (
    input  RX_IN, Prescale, Par_En, Par_Typ, Stp_2,
    output P_DATA, Data_Valid, Par_Err, Stp_Err, Brk_Det, Busy
  );
endinterface

// File: rtl/uart_rx_ctrl_param.sv
// ----------------------------------------------------------------------------
// uart_rx_ctrl_param
//   UART receive controller: start detection, per-bit edge counting,
//   3-sample majority vote, LSB-first deserialisation, optional even/odd
//   parity, one or two stop bits, registered result/error pulses.
//   clk, rst_n (async, active low)
//   rx_if.slave : RX_IN, Prescale, Par_En, Par_Typ, Stp_2 in;
//                 P_DATA, Data_Valid, Par_Err, Stp_Err, Brk_Det, Busy out
//   Optional: define UART_RX_BREAK_DET_EN to add line-break detection
//   (BREAK state, Brk_Det pulse); otherwise Brk_Det is tied 0.
// ----------------------------------------------------------------------------
module uart_rx_ctrl_param #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_rx_ctrl_param_if.slave  rx_if
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
`ifdef UART_RX_BREAK_DET_EN
    ,BREAK = 3'd5
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [3:0]            bit_q, bit_d;
  logic [2:0]            samp_q, samp_d;
  logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic                  bad_q, bad_d;
  logic [PRESCALE_W-1:0] p_q, p_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  stp2_q, stp2_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic                  dv_q, dv_d;
  logic                  pe_q, pe_d;
  logic                  se_q, se_d;
  logic                  bd_q, bd_d;
  logic                  busy_q, busy_d;

  logic [PRESCALE_W-1:0] half;
  logic                  last_edge;
  logic                  is_check;
  logic                  maj;

  always_comb begin
    state_d   = state_q;
    edge_d    = edge_q;
    bit_d     = bit_q;
    samp_d    = samp_q;
    shadow_d  = shadow_q;
    bad_d     = bad_q;
    p_d       = p_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    stp2_d    = stp2_q;
    pdata_d   = pdata_q;
    dv_d      = 1'b0;
    pe_d      = 1'b0;
    se_d      = 1'b0;
    bd_d      = 1'b0;

    half      = p_q >> 1;
    last_edge = (edge_q == p_q - PRESCALE_W'(1));
    is_check  = (edge_q == half + PRESCALE_W'(2));
    maj       = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) |
                (samp_q[1] & samp_q[2]);

    if (state_q == START || state_q == DATA || state_q == PARITY ||
        state_q == STOP) begin
      edge_d = last_edge ? '0 : edge_q + PRESCALE_W'(1);
      if (edge_q == half - PRESCALE_W'(1)) samp_d[0] = rx_if.RX_IN;
      if (edge_q == half)                  samp_d[1] = rx_if.RX_IN;
      if (edge_q == half + PRESCALE_W'(1)) samp_d[2] = rx_if.RX_IN;
    end

    unique case (state_q)
      IDLE: begin
        if (!rx_if.RX_IN) begin
          // The detection cycle itself is edge 0 of the start bit.
          state_d   = START;
          edge_d    = PRESCALE_W'(1);
          bit_d     = '0;
          bad_d     = 1'b0;
          p_d       = (rx_if.Prescale < PRESCALE_W'(8)) ? PRESCALE_W'(8)
                      : {rx_if.Prescale[PRESCALE_W-1:1], 1'b0};
          par_en_d  = rx_if.Par_En;
          par_typ_d = rx_if.Par_Typ;
          stp2_d    = rx_if.Stp_2;
        end
      end
      START: begin
        if (is_check && maj) begin
          state_d = IDLE;
          edge_d  = '0;
        end else if (last_edge) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (is_check) shadow_d = {maj, shadow_q[DATA_WIDTH-1:1]};
        if (last_edge) begin
          if (bit_q == 4'(DATA_WIDTH - 1)) begin
            bit_d   = '0;
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      PARITY: begin
        if (is_check && (maj != (^shadow_q ^ par_typ_q))) begin
          pe_d  = 1'b1;
          bad_d = 1'b1;
        end
        if (last_edge) begin
          state_d = STOP;
          bit_d   = '0;
        end
      end
      STOP: begin
        if (is_check && !maj) begin
          edge_d  = '0;
          state_d = IDLE;
`ifdef UART_RX_BREAK_DET_EN
          if (shadow_q == '0) begin
            bd_d    = 1'b1;
            state_d = BREAK;
          end else begin
            se_d = 1'b1;
          end
`else
          se_d = 1'b1;
`endif
        end else if (is_check && (!stp2_q || bit_q == 4'd1)) begin
          // Leave half a bit early so the next start edge is not missed.
          edge_d  = '0;
          state_d = IDLE;
          if (!bad_q) begin
            pdata_d = shadow_q;
            dv_d    = 1'b1;
          end
        end else if (last_edge) begin
          bit_d = 4'd1;
        end
      end
`ifdef UART_RX_BREAK_DET_EN
      BREAK: begin
        edge_d = '0;
        if (rx_if.RX_IN) state_d = IDLE;
      end
`endif
      default: begin
        state_d = IDLE;
        edge_d  = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      edge_q    <= '0;
      bit_q     <= '0;
      samp_q    <= '0;
      shadow_q  <= '0;
      bad_q     <= 1'b0;
      p_q       <= PRESCALE_W'(8);
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      stp2_q    <= 1'b0;
      pdata_q   <= '0;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      se_q      <= 1'b0;
      bd_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      edge_q    <= edge_d;
      bit_q     <= bit_d;
      samp_q    <= samp_d;
      shadow_q  <= shadow_d;
      bad_q     <= bad_d;
      p_q       <= p_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      stp2_q    <= stp2_d;
      pdata_q   <= pdata_d;
      dv_q      <= dv_d;
      pe_q      <= pe_d;
      se_q      <= se_d;
      bd_q      <= bd_d;
      busy_q    <= busy_d;
    end
  end

  assign rx_if.P_DATA     = pdata_q;
  assign rx_if.Data_Valid = dv_q;
  assign rx_if.Par_Err    = pe_q;
  assign rx_if.Stp_Err    = se_q;
  assign rx_if.Busy       = busy_q;
`ifdef UART_RX_BREAK_DET_EN
  assign rx_if.Brk_Det    = bd_q;
`else
  assign rx_if.Brk_Det    = 1'b0;
  logic unused_bd;
  assign unused_bd = bd_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl_param.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_ctrl_param
//   Directed frames on two instances (8-bit and 5-bit data). Cycle c of a
//   frame is the cycle whose RX_IN value is captured at the following rising
//   edge; cycle 0 is the IDLE cycle that sees the start bit low. Outputs are
//   sampled on the falling edge inside each cycle.
// ----------------------------------------------------------------------------
module tb_uart_rx_ctrl_param;

  logic clk;
  logic rst_n;

  uart_rx_ctrl_param_if #(.DATA_WIDTH(8), .PRESCALE_W(6)) a_if ();
  uart_rx_ctrl_param_if #(.DATA_WIDTH(5), .PRESCALE_W(6)) b_if ();

  uart_rx_ctrl_param #(.DATA_WIDTH(8), .PRESCALE_W(6)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_if (a_if.slave)
  );

  uart_rx_ctrl_param #(.DATA_WIDTH(5), .PRESCALE_W(6)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_if (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // per-frame observations
  int unsigned n_dv, n_pe, n_se, n_bd;
  int          c_dv, c_pe, c_se, c_bd, c_idle;
  logic        busy_probe;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               tag, got, got, exp, exp);
    end
  endtask

  // Drive one line pattern: bit k of `bits` occupies cycles kP..kP+P-1,
  // then the line idles high for `extra` cycles. Cycles [gl_c, gl_c+gl_n)
  // are inverted.
  task automatic drive(input bit sel, input int unsigned p,
                       input logic [31:0] bits, input int unsigned nbits,
                       input int unsigned extra, input int gl_c,
                       input int unsigned gl_n, input int unsigned probe);
    logic line, dv, pe, se, bd, busy;
    n_dv = 0; n_pe = 0; n_se = 0; n_bd = 0;
    c_dv = -1; c_pe = -1; c_se = -1; c_bd = -1; c_idle = -1;
    busy_probe = 1'b0;
    for (int unsigned c = 0; c < nbits * p + extra; c++) begin
      @(negedge clk);
      if (sel) {dv, pe, se, bd, busy} = {b_if.Data_Valid, b_if.Par_Err,
                                         b_if.Stp_Err, b_if.Brk_Det, b_if.Busy};
      else     {dv, pe, se, bd, busy} = {a_if.Data_Valid, a_if.Par_Err,
                                         a_if.Stp_Err, a_if.Brk_Det, a_if.Busy};
      if (dv) begin n_dv++; if (c_dv < 0) c_dv = int'(c); end
      if (pe) begin n_pe++; if (c_pe < 0) c_pe = int'(c); end
      if (se) begin n_se++; if (c_se < 0) c_se = int'(c); end
      if (bd) begin n_bd++; if (c_bd < 0) c_bd = int'(c); end
      if (c > 0 && !busy && c_idle < 0) c_idle = int'(c);
      if (c == probe) busy_probe = busy;
      line = (c < nbits * p) ? bits[c / p] : 1'b1;
      if (int'(c) >= gl_c && int'(c) < gl_c + int'(gl_n)) line = ~line;
      if (sel) b_if.RX_IN = line;
      else     a_if.RX_IN = line;
    end
  endtask

  task automatic cfg_a(input logic [5:0] p, input logic pen, input logic pt,
                       input logic s2);
    a_if.Prescale = p; a_if.Par_En = pen; a_if.Par_Typ = pt; a_if.Stp_2 = s2;
  endtask

  initial begin
    rst_n = 1'b0;
    a_if.RX_IN = 1'b1; b_if.RX_IN = 1'b1;
    cfg_a(6'd8, 1'b0, 1'b0, 1'b0);
    b_if.Prescale = 6'd8; b_if.Par_En = 1'b0; b_if.Par_Typ = 1'b0;
    b_if.Stp_2 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst busy", 32'(a_if.Busy), 32'd0);
    check("rst pdata", 32'(a_if.P_DATA), 32'd0);
    check("rst dv", 32'(a_if.Data_Valid), 32'd0);
    check("rst stperr", 32'(a_if.Stp_Err), 32'd0);
    check("rst b busy", 32'(b_if.Busy), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 0xA5, P=8, 8N1
    drive(1'b0, 8, 32'({1'b1, 8'hA5, 1'b0}), 10, 8, -1, 0, 1);
    check("a5 busy c1", 32'(busy_probe), 32'd1);
    check("a5 dv cycle", 32'(c_dv), 32'd79);
    check("a5 dv count", n_dv, 32'd1);
    check("a5 busy fall", 32'(c_idle), 32'd79);
    check("a5 pdata", 32'(a_if.P_DATA), 32'hA5);
    check("a5 err pulses", n_pe + n_se + n_bd, 32'd0);

    // 0x3C, P=16, odd parity, correct parity bit = 1
    cfg_a(6'd16, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 16, 32'({1'b1, 1'b1, 8'h3C, 1'b0}), 11, 8, -1, 0, 0);
    check("par ok dv cycle", 32'(c_dv), 32'd171);
    check("par ok pdata", 32'(a_if.P_DATA), 32'h3C);
    check("par ok perr", n_pe, 32'd0);

    // 0x81 with wrong odd-parity bit (correct would be 1)
    drive(1'b0, 16, 32'({1'b1, 1'b0, 8'h81, 1'b0}), 11, 8, -1, 0, 0);
    check("par bad perr count", n_pe, 32'd1);
    check("par bad perr cycle", 32'(c_pe), 32'd155);
    check("par bad dv", n_dv, 32'd0);
    check("par bad pdata kept", 32'(a_if.P_DATA), 32'h3C);

    // start glitch: low for cycles 0..2 only
    cfg_a(6'd8, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8, 32'h1, 1, 8, 0, 3, 0);
    check("glitch idle cycle", 32'(c_idle), 32'd7);
    check("glitch pulses", n_dv + n_pe + n_se + n_bd, 32'd0);

    // W=5, two stop bits, second stop low
    drive(1'b1, 8, 32'({1'b0, 1'b1, 5'h16, 1'b0}), 8, 16, -1, 0, 0);
    check("stp2 serr count", n_se, 32'd1);
    check("stp2 serr cycle", 32'(c_se), 32'd63);
    check("stp2 dv", n_dv, 32'd0);
    check("stp2 pdata kept", 32'(b_if.P_DATA), 32'd0);

    // W=5, two good stop bits, one-cycle glitch on the middle sample of d0
    drive(1'b1, 8, 32'({1'b1, 1'b1, 5'h0B, 1'b0}), 8, 8, 12, 1, 0);
    check("w5 dv cycle", 32'(c_dv), 32'd63);
    check("w5 pdata", 32'(b_if.P_DATA), 32'h0B);
    check("w5 errs", n_se + n_pe, 32'd0);

    // line held low for two frame times (160 cycles)
    drive(1'b0, 8, 32'h0, 20, 16, -1, 0, 120);
    check("brk dv", n_dv, 32'd0);
    check("brk busy mid", 32'(busy_probe), 32'd1);
`ifdef UART_RX_BREAK_DET_EN
    check("brk bd count", n_bd, 32'd1);
    check("brk bd cycle", 32'(c_bd), 32'd79);
    check("brk serr", n_se, 32'd0);
    check("brk busy fall", 32'(c_idle), 32'd161);
`else
    check("brk bd", n_bd, 32'd0);
    check("brk serr count", n_se, 32'd2);
    check("brk serr cycle", 32'(c_se), 32'd79);
    check("brk idle cycle", 32'(c_idle), 32'd79);
`endif

    // reset in the middle of DATA
    drive(1'b0, 8, 32'({1'b1, 8'hFF, 1'b0}), 3, 0, -1, 0, 0);
    @(negedge clk);
    check("mid busy before rst", 32'(a_if.Busy), 32'd1);
    rst_n = 1'b0;
    a_if.RX_IN = 1'b1;
    #1;
    check("mid rst busy", 32'(a_if.Busy), 32'd0);
    check("mid rst pdata", 32'(a_if.P_DATA), 32'd0);
    check("mid rst dv", 32'(a_if.Data_Valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    drive(1'b0, 8, 32'({1'b1, 8'h5A, 1'b0}), 10, 8, -1, 0, 0);
    check("post rst dv cycle", 32'(c_dv), 32'd79);
    check("post rst pdata", 32'(a_if.P_DATA), 32'h5A);
    check("post rst errs", n_pe + n_se + n_bd, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
